// File: rtl/pipeline_mem_arbiter_pkg.sv
// rtl/pipeline_mem_arbiter_pkg.sv - shared state encodings and arbitration helper for the IF/MEM memory arbiter
package pipeline_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // MEM wins a collision until it has taken its allowance of back-to-back grants while IF waits
    function automatic logic d_wins(input logic d_req, input logic if_req, input logic streak_full);
        return d_req & (~if_req | ~streak_full);
    endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_streak_counter.sv
// rtl/pipeline_mem_arbiter_streak_counter.sv - saturating count of consecutive MEM grants taken while IF waits
module arb_streak_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic full_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_W'(MAX_COUNT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o = (count_q == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// rtl/pipeline_mem_arbiter.sv - shares one single-ported memory between the IF and MEM pipeline stages
import pipeline_mem_arbiter_pkg::*;

module pipeline_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic streak_clr;
    logic streak_inc;
    logic streak_full;

    arb_streak_counter #(
        .MAX_COUNT (MAX_D_STREAK)
    ) u_streak (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (streak_clr),
        .inc_i  (streak_inc),
        .full_o (streak_full)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        streak_clr  = 1'b0;
        streak_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_wins(d_req, if_req, streak_full)) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // a MEM grant only counts against IF when IF is actually waiting
                    streak_inc  = if_req;
                    streak_clr  = ~if_req;
                end else if (if_req) begin
                    state_d     = ST_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    streak_clr  = 1'b1;
                end else begin
                    streak_clr  = 1'b1;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // an ack arriving while IDLE belongs to no access and is dropped here
    assign if_ready  = (state_q == ST_BUSY_I) & mem_ack;
    assign d_ready   = (state_q == ST_BUSY_D) & mem_ack;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
